// File: rtl/led_sched_pkg.sv
// led_sched_pkg
// Shared types and helpers for the LED blink-code scheduler.
//   - state_t   : frame player states (IDLE, SOLID, ON, OFF, GAP)
//   - CODE_W    : width of one requester's pulse-count code
//   - prio_enc  : lowest-set-index priority encoder with a valid flag,
//                 sized for up to MAX_REQ requesters (callers zero-extend)
package led_sched_pkg;

    localparam int CODE_W  = 4;
    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOLID,
        ST_ON,
        ST_OFF,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } prio_t;

    // Index 0 wins: scan from the top so the lowest set bit is written last.
    function automatic prio_t prio_enc(input logic [MAX_REQ-1:0] vec);
        prio_t res;
        res.valid = 1'b0;
        res.idx   = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res.valid = 1'b1;
                res.idx   = IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/led_code_scheduler_tick.sv
// led_tick_gen
// Prescaler producing a one-cycle tick every TICK_DIV clk cycles.
// Ports:
//   clk       in  : system clock
//   rst       in  : synchronous active-high reset
//   i_restart in  : forces the count back to 0 on the next edge
//   o_tick    out : high on the cycle the count equals TICK_DIV-1
module led_tick_gen #(
    parameter int TICK_DIV = 8400000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_tick_cnt;

    assign o_tick = (r_tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || i_restart || o_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_code_scheduler.sv
// led_code_scheduler
// Arbitrates NUM_REQ status requesters (index 0 highest priority) and plays
// the winner's blink code on one LED: K pulses then a low gap, or, for
// code 0, a solid-high frame. A new owner is chosen only at frame boundaries.
// Optional build macro: LED_SCHED_PREEMPT_EN -- a strictly higher-priority
// request aborts the running frame and starts its own on the next cycle.
// Ports:
//   clk   in  : system clock
//   rst   in  : synchronous active-high reset
//   req   in  : level request per requester
//   code  in  : 4-bit pulse count per requester (0 = solid on)
//   led   out : registered LED drive
//   grant out : one-hot frame owner, held for the whole frame
//   busy  out : high while a frame is playing
module led_code_scheduler
    import led_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TICK_DIV  = 8400000,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 2,
    parameter int GAP_TICKS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [CODE_W*NUM_REQ-1:0] code,
    output logic                      led,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy
);

    localparam int MAX_PH = (ON_TICKS > OFF_TICKS) ?
                            ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS) :
                            ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
    localparam int PH_W = $clog2(MAX_PH + 1);

    state_t              r_state, w_state_next;
    logic [PH_W-1:0]     r_ph_cnt, w_ph_next;
    logic [CODE_W-1:0]   r_pulses_left, w_pulses_next;
    logic [NUM_REQ-1:0]  r_grant, w_grant_next;
    logic                r_busy, w_busy_next;
    logic                r_led, w_led_next;

    logic                w_tick;
    logic                w_start;
    logic                w_frame_end;
    logic                w_phase_end;
    logic [PH_W-1:0]     w_phase_last;
    prio_t               w_arb;
    logic [CODE_W-1:0]   w_sel_code;
    logic [CODE_W-1:0]   w_code [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_code_split
        assign w_code[gi] = code[gi*CODE_W +: CODE_W];
    end

    assign w_arb = prio_enc(MAX_REQ'(req));

    always_comb begin
        w_sel_code = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb.idx == IDX_W'(i)) begin
                w_sel_code = w_code[i];
            end
        end
    end

    // Holding the prescaler in restart while idle means every frame's first
    // tick lands exactly TICK_DIV cycles after the frame starts.
    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_start || (r_state == ST_IDLE)),
        .o_tick    (w_tick)
    );

    always_comb begin
        case (r_state)
            ST_ON:   w_phase_last = PH_W'(ON_TICKS - 1);
            ST_OFF:  w_phase_last = PH_W'(OFF_TICKS - 1);
            default: w_phase_last = PH_W'(GAP_TICKS - 1);
        endcase
    end

    assign w_phase_end = w_tick && (r_ph_cnt == w_phase_last);

    always_comb begin
        w_state_next  = r_state;
        w_ph_next     = r_ph_cnt;
        w_pulses_next = r_pulses_left;
        w_grant_next  = r_grant;
        w_busy_next   = r_busy;
        w_start       = 1'b0;
        w_frame_end   = 1'b0;

        if (r_state != ST_IDLE && w_tick) begin
            w_ph_next = r_ph_cnt + PH_W'(1);
        end

        case (r_state)
            ST_IDLE: begin
                w_start = w_arb.valid;
            end
            ST_SOLID, ST_GAP: begin
                w_frame_end = w_phase_end;
            end
            ST_ON: begin
                if (w_phase_end) begin
                    w_ph_next    = '0;
                    w_state_next = (r_pulses_left > CODE_W'(1)) ? ST_OFF : ST_GAP;
                end
            end
            ST_OFF: begin
                if (w_phase_end) begin
                    w_ph_next     = '0;
                    w_pulses_next = r_pulses_left - CODE_W'(1);
                    w_state_next  = ST_ON;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

`ifdef LED_SCHED_PREEMPT_EN
        // Any request below the owner's bit outranks it.
        if (r_state != ST_IDLE && (req & (r_grant - NUM_REQ'(1))) != '0) begin
            w_start = 1'b1;
        end
`endif

        if (w_frame_end && w_arb.valid) begin
            w_start = 1'b1;
        end

        if (w_start) begin
            w_ph_next     = '0;
            w_pulses_next = w_sel_code;
            w_grant_next  = NUM_REQ'(1) << w_arb.idx;
            w_busy_next   = 1'b1;
            w_state_next  = (w_sel_code == '0) ? ST_SOLID : ST_ON;
        end else if (w_frame_end) begin
            w_ph_next     = '0;
            w_pulses_next = '0;
            w_grant_next  = '0;
            w_busy_next   = 1'b0;
            w_state_next  = ST_IDLE;
        end

        // LED follows the state being entered so it moves on the same edge.
        w_led_next = (w_state_next == ST_SOLID) || (w_state_next == ST_ON);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ph_cnt      <= '0;
            r_pulses_left <= '0;
            r_grant       <= '0;
            r_busy        <= 1'b0;
            r_led         <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_ph_cnt      <= w_ph_next;
            r_pulses_left <= w_pulses_next;
            r_grant       <= w_grant_next;
            r_busy        <= w_busy_next;
            r_led         <= w_led_next;
        end
    end

    assign led   = r_led;
    assign grant = r_grant;
    assign busy  = r_busy;

endmodule

// File: doc/led_code_scheduler.md
# led_code_scheduler

Single-LED blink-code scheduler. It arbitrates between `NUM_REQ` status requesters and plays the winner's pulse code (N blinks then a gap, or solid on) on one board LED. It sits between status decode logic (transmission, loop-limit, error flags) and the LED pin, and it is the sole driver of that pin. A new frame is chosen only at frame boundaries, so patterns never glitch or truncate.

## Interface
- `NUM_REQ`, 4: number of requesters. Index 0 has the highest priority.
- `TICK_DIV`, 8400000: `clk` cycles per tick.
- `ON_TICKS`, 2: ticks the LED is high per pulse.
- `OFF_TICKS`, 2: ticks the LED is low between pulses.
- `GAP_TICKS`, 8: ticks at the end of every frame. The LED is low after a pulse code and high after a solid frame.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `req` in NUM_REQ: level request per requester.
- `code` in 4*NUM_REQ: pulse count per requester, 4 bits each. 0 means solid on.
- `led` out 1: registered LED drive. Resets to 0.
- `grant` out NUM_REQ: one-hot frame owner, held for the whole frame. Resets to 0.
- `busy` out 1: high while a frame is playing. Resets to 0.

## Operation
- Prescaler `tick_cnt` has width clog2(TICK_DIV). `tick` pulses on the cycle `tick_cnt == TICK_DIV-1`. The prescaler restarts at 0 on every frame start.
- Phase counter `ph_cnt` counts ticks within the current phase and clears on every state change.
- States:
  - IDLE: `led=0`, `busy=0`, `grant=0`. On any `req` bit, arbitrate.
  - SOLID: `led=1` for GAP_TICKS, then it is a frame end.
  - ON: `led=1` for ON_TICKS. Then go to OFF if `pulses_left>1`, otherwise go to GAP.
  - OFF: `led=0` for OFF_TICKS. Decrement `pulses_left`, then go to ON.
  - GAP: `led=0` for GAP_TICKS, then it is a frame end.
- Arbitration picks the lowest set index of `req`. It latches that requester's `code` into `cur_code`/`pulses_left` and sets `grant`. It enters SOLID if the code is 0, otherwise ON.
- Frame end: arbitrate again in the same cycle. With no request, go to IDLE.
  - SOLID → SOLID for the same or another solid requester keeps `led` at 1 continuously.
- Changes to `req` or `code` mid-frame are ignored. The frame always completes. Deasserting the owner's `req` does not shorten the frame.
- Frame length for code K≥1 is K*ON_TICKS + (K-1)*OFF_TICKS + GAP_TICKS ticks. For code 0 it is GAP_TICKS.
- Reset at any point: next cycle the block is in IDLE with `led=0`, `grant=0`, `busy=0`, and all counters at 0.

## Timing
- Request while IDLE: the frame starts the cycle after `req` is sampled. `led`, `grant` and `busy` all update on that same edge, giving 1-cycle latency.
- Each phase lasts exactly (phase ticks × TICK_DIV) cycles, because the prescaler restarts at frame start.
- Back-to-back frames have no idle cycle. The next frame's first phase begins the cycle after the previous frame's last tick.
- `grant` and `busy` change only at frame start, frame end to IDLE, or reset.

## Configuration
- `LED_SCHED_PREEMPT_EN` defined: while in ON, OFF or GAP, a `req` bit of strictly higher priority than the current owner aborts the frame. On the next cycle a new frame starts for that requester, with the prescaler restarted. SOLID frames are preempted the same way.
- `LED_SCHED_PREEMPT_EN` undefined: no preemption. Frames always complete.

## Structure
- Package `led_sched_pkg` holds:
  - the state enum (IDLE, SOLID, ON, OFF, GAP);
  - `CODE_W=4`;
  - the priority-encode function (lowest set index, plus a valid flag).
- Sub-module `led_tick_gen` holds the prescaler with a synchronous restart input and a `tick` output.

## Test plan
Parameters for all scenarios: TICK_DIV=4, ON_TICKS=2, OFF_TICKS=2, GAP_TICKS=6.
- `req[2]=1`, `code[2]=3` from IDLE:
  - `grant=4'b0100` on the next edge.
  - `led` runs high 8, low 8, high 8, low 8, high 8, then low 24 cycles, for 64 cycles total.
  - `busy` is low after one more idle cycle if `req` has dropped.
- `req[1]=1`, `code[1]=0` held:
  - `led` stays high continuously across three frames with no glitch cycle.
  - `grant=4'b0010` throughout.
- `req[3]` (code 2) mid-frame, then `req[0]` (code 1) asserted during the first ON phase:
  - Without preempt: the code-2 frame completes in 48 cycles, then `grant=4'b0001`.
  - With `LED_SCHED_PREEMPT_EN`: `grant=4'b0001` on the next cycle and an 8-cycle pulse starts.
- Owner deasserts `req` during OFF: the frame still completes at its full length, then the block goes to IDLE with `led=0`.
- `rst` pulsed during an ON phase: next cycle `led=0`, `grant=0`, `busy=0`. With `req` still held, the frame restarts from the first pulse one cycle after `rst` drops.
